dm_access_bridge: RTL and testbench

//  Sits directly downstream of the CPU data-memory port (MEM stage).

---
 rtl/dm_access_bridge.sv | 101 ++++++++++
 tb/tb_dm_access_bridge.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dm_access_bridge.sv
// rtl/dm_access_bridge.sv - CPU SRAM-style DM port to valid/ready multi-cycle memory bridge
module dm_access_bridge #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_web,
  input  logic [31:0]       cpu_bweb,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_strb,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic              err_flag
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          access;
  logic          write_sel;
  logic [3:0]    strb_next;

  // A store takes priority when the CPU raises both load and store together.
  assign write_sel = ~cpu_web;
  assign access    = cpu_re | write_sel;

  always_comb begin
    strb_next = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      strb_next[i] = write_sel & ~(&cpu_bweb[8*i +: 8]);
    end
  end

  assign cpu_stall = ((state == S_IDLE) & access) | (state == S_REQ) | (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      timer         <= '0;
      cpu_rdata     <= 32'h0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= 32'h0;
      mem_req_strb  <= 4'b0000;
      err_flag      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            mem_req_write <= write_sel;
            mem_req_addr  <= cpu_addr;
            mem_req_wdata <= cpu_wdata;
            mem_req_strb  <= strb_next;
            mem_req_valid <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            timer         <= '0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            if (!mem_req_write) begin
              cpu_rdata <= mem_resp_data;
            end
            state <= S_DONE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            // Abort: the CPU gets zero data and the sticky error records it.
            err_flag  <= 1'b1;
            cpu_rdata <= 32'h0;
            state     <= S_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_bridge.sv
// tb/tb_dm_access_bridge.sv - directed self-checking bench for dm_access_bridge
module tb_dm_access_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re;
  logic        cpu_web;
  logic [31:0] cpu_bweb;
  logic [13:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [13:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_strb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        err_flag;

  int tests  = 0;
  int errors = 0;

  int          stalls;
  logic [31:0] rd;

  always #5 clk = ~clk;

  dm_access_bridge #(.ADDR_W(14), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_web(cpu_web), .cpu_bweb(cpu_bweb),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_strb(mem_req_strb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .err_flag(err_flag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu_idle();
    cpu_re    = 1'b0;
    cpu_web   = 1'b1;
    cpu_bweb  = 32'hFFFF_FFFF;
    cpu_addr  = 14'h0;
    cpu_wdata = 32'h0;
  endtask

  // Drives one CPU access from an IDLE-cycle negedge and plays the memory side.
  // Returns at the negedge of the cycle after DONE with CPU inputs released.
  task automatic do_access(input logic wr, input logic rdq, input logic [13:0] a,
                           input logic [31:0] wd, input logic [31:0] bw,
                           input logic [3:0] exp_strb, input int rdy_dly,
                           input int rsp_dly, input logic rsp_en,
                           input logic [31:0] rsp_data,
                           output int n_stall, output logic [31:0] rdata_done);
    int   vcnt;
    int   wcnt;
    logic hs;
    logic finished;
    n_stall = 0; vcnt = 0; wcnt = 0; hs = 1'b0; finished = 1'b0;
    rdata_done = 32'h0;
    cpu_re = rdq; cpu_web = ~wr; cpu_bweb = bw; cpu_addr = a; cpu_wdata = wd;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (hs) wcnt++;
      mem_req_ready  = mem_req_valid && (vcnt >= rdy_dly);
      mem_resp_valid = rsp_en && hs && (wcnt == rsp_dly);
      mem_resp_data  = mem_resp_valid ? rsp_data : 32'hDEAD_BEEF;
      #1;
      if (!cpu_stall) begin
        rdata_done = cpu_rdata;
        finished = 1'b1;
        break;
      end
      n_stall++;
      if (mem_req_valid) begin
        check("req_addr", 32'(mem_req_addr), 32'(a));
        check("req_write", 32'(mem_req_write), 32'(wr));
        check("req_strb", 32'(mem_req_strb), 32'(exp_strb));
        if (wr) check("req_wdata", mem_req_wdata, wd);
        if (mem_req_ready) begin
          hs = 1'b1;
          wcnt = 0;
        end else begin
          vcnt++;
        end
      end
      @(negedge clk);
    end
    if (!finished) check("access_bound", 32'd0, 32'd1);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    cpu_idle();
    #1;
    check("idle_no_reissue", 32'(mem_req_valid), 32'd0);
    check("idle_stall", 32'(cpu_stall), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cpu_idle();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_valid", 32'(mem_req_valid), 32'd0);
    check("rst_err", 32'(err_flag), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_addr", 32'(mem_req_addr), 32'd0);
    check("rst_strb", 32'(mem_req_strb), 32'd0);
    @(negedge clk);

    // Read: 1 IDLE + 1 REQ + 3 WAIT = 5 stall cycles
    do_access(1'b0, 1'b1, 14'h010, 32'h0, 32'hFFFF_FFFF, 4'b0000, 0, 3, 1'b1,
              32'hCAFE_0001, stalls, rd);
    check("rd_stalls", 32'(stalls), 32'd5);
    check("rd_data", rd, 32'hCAFE_0001);

    // Write with byte 1 enabled; ack data must not reach cpu_rdata
    do_access(1'b1, 1'b0, 14'h020, 32'h1234_5678, 32'hFFFF_00FF, 4'b0010, 0, 1, 1'b1,
              32'hBAD0_BAD0, stalls, rd);
    check("wr_stalls", 32'(stalls), 32'd3);
    check("wr_rdata_kept", rd, 32'hCAFE_0001);

    // Backpressure: ready low for 5 REQ cycles -> 1 + 6 + 2 stalls
    do_access(1'b1, 1'b0, 14'h3FFF, 32'hA5A5_A5A5, 32'h0000_0000, 4'b1111, 5, 2, 1'b1,
              32'h0, stalls, rd);
    check("bp_stalls", 32'(stalls), 32'd9);
    check("bp_rdata_kept", rd, 32'hCAFE_0001);

    do_access(1'b0, 1'b1, 14'h001, 32'h0, 32'hFFFF_FFFF, 4'b0000, 0, 1, 1'b1,
              32'h0BAD_F00D, stalls, rd);
    check("rd2_stalls", 32'(stalls), 32'd3);
    check("rd2_data", rd, 32'h0BAD_F00D);

    // Timeout with TIMEOUT=8: 1 + 1 + 8 stalls, data zeroed, sticky error
    do_access(1'b0, 1'b1, 14'h002, 32'h0, 32'hFFFF_FFFF, 4'b0000, 0, 0, 1'b0,
              32'h0, stalls, rd);
    check("to_stalls", 32'(stalls), 32'd10);
    check("to_rdata", rd, 32'h0);
    check("to_err", 32'(err_flag), 32'd1);

    do_access(1'b0, 1'b1, 14'h003, 32'h0, 32'hFFFF_FFFF, 4'b0000, 1, 2, 1'b1,
              32'h7777_8888, stalls, rd);
    check("post_to_stalls", 32'(stalls), 32'd5);
    check("post_to_data", rd, 32'h7777_8888);
    check("err_sticky", 32'(err_flag), 32'd1);

    // Back-to-back read then combined re+we (write wins)
    do_access(1'b0, 1'b1, 14'h004, 32'h0, 32'hFFFF_FFFF, 4'b0000, 0, 1, 1'b1,
              32'h1111_2222, stalls, rd);
    check("b2b_rd_data", rd, 32'h1111_2222);
    do_access(1'b1, 1'b1, 14'h005, 32'h3333_4444, 32'h00FF_FFFF, 4'b1000, 0, 1, 1'b1,
              32'h9999_9999, stalls, rd);
    check("b2b_wr_stalls", 32'(stalls), 32'd3);
    check("b2b_wr_rdata_kept", rd, 32'h1111_2222);

    // Reset while in WAIT
    cpu_re = 1'b1; cpu_addr = 14'h006;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    check("wait_stall", 32'(cpu_stall), 32'd1);
    rst = 1'b1;
    cpu_idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(mem_req_valid), 32'd0);
    check("mid_rst_stall", 32'(cpu_stall), 32'd0);
    check("mid_rst_err", 32'(err_flag), 32'd0);
    check("mid_rst_rdata", cpu_rdata, 32'd0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_5555;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    check("late_resp_rdata", cpu_rdata, 32'd0);
    check("late_resp_stall", 32'(cpu_stall), 32'd0);
    check("late_resp_valid", 32'(mem_req_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
